pu_mac_stream: RTL and testbench
================================

// Module: pu_mac_stream
// PURPOSE
//  Parametrised, pipelined multi-lane dot-product processing unit; successor of the fixed 4-lane PU.
//  Each accepted beat multiplies LANES input/weight pairs, reduces them in an adder tree and
//  accumulates across beats until in_last; the saturated result is emitted with valid/ready.
//  Sits between the input/weight buffers and the activation stage of the datapath.
// PARAMETERS
//  LANES    4   number of input/weight pairs per beat (power of 2, >=2)
//  DATA_W   5   width of each input and weight element
//  ACC_W    16  accumulator and out_data width (>= 2*DATA_W+clog2(LANES))
//  CNT_W    8   beat counter width (out_beats)
//  SIGNED   0   0: unsigned operands; 1: two's-complement operands, products and result
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-low reset
//  in_valid   in   1              beat present on in_data/in_wgt/in_last
//  in_ready   out  1              unit can accept a beat this cycle
//  in_data    in   LANES*DATA_W   lane i = in_data[i*DATA_W +: DATA_W]
//  in_wgt     in   LANES*DATA_W   lane i weight, same packing
//  in_last    in   1              final beat of the current accumulation packet
//  out_valid  out  1              result available
//  out_ready  in   1              downstream accepts result
//  out_data   out  ACC_W          accumulated, saturated dot product
//  out_sat    out  1              saturation occurred anywhere in this packet
//  out_beats  out  CNT_W          beats accumulated in this packet (saturates at 2^CNT_W-1)
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids, accumulator, beat counter, out_valid, out_data,
//    out_sat, out_beats cleared to 0; in_ready=0 while rst=0, 1 in first cycle after release.
//  - stall = out_valid & ~out_ready; in_ready = ~stall; beat accepted on edge with in_valid & in_ready.
//  - Pipeline, all stages frozen (hold data and valid) while stall=1:
//    S1: per-lane product register, PROD_W=2*DATA_W, plus v1/last1.
//    S2: balanced adder-tree sum register, SUM_W=PROD_W+clog2(LANES), sign-extended if SIGNED, v2/last2.
//    S3: accumulator/output. On v2: nxt = acc + sum (full precision, ACC_W+1 bits).
//        last2=0: acc<=sat(nxt), cnt++, sat_flag|=overflow.
//        last2=1: out_data<=sat(nxt), out_sat<=sat_flag|overflow, out_beats<=cnt+1, out_valid<=1;
//        acc, cnt, sat_flag cleared the same edge (next packet starts clean).
//  - Latency: beat with in_last accepted on edge E0 -> out_valid high after edge E0+2; one beat/cycle.
//  - Saturation: unsigned clamps to 2^ACC_W-1; signed clamps to +2^(ACC_W-1)-1 / -2^(ACC_W-1).
//    Accumulator stays clamped; later beats add to the clamped value.
//  - out_valid drops on edge with out_ready=1 unless a new result is written the same edge
//    (back-to-back results allowed). out_data/out_sat/out_beats stable while out_valid & ~out_ready.
//  - Single-beat packet (in_last on first beat) legal: out_beats=1.
//  - Bubbles (in_valid=0) between beats of a packet do not affect the accumulator.
//  - Reset mid-packet discards partial accumulation and any in-flight beats; no output produced.
// TESTING
//  1 LANES=4,DATA_W=5,SIGNED=0: data{1,2,3,4} wgt{5,6,7,8} last=1 -> out_data=70, beats=1, sat=0, 3 edges.
//  2 same beat x3, last on 3rd, one idle cycle between beats -> out_data=210, out_beats=3.
//  3 ACC_W=12: all lanes 31x31 for 2 beats (3844 each) -> out_data=4095, out_sat=1; next packet sat=0.
//  4 SIGNED=1: all lanes data=-16 wgt=15, last=1 -> out_data=-960 (two's complement, ACC_W bits).
//  5 back-pressure: out_ready=0 for 5 cycles with 2 packets queued -> in_ready=0, out_data stable,
//    both results (70, 210) delivered in order, none lost or duplicated.
//  6 rst low for 1 cycle after 2nd of 3 beats -> all outputs 0; next 1-beat packet gives 70, beats=1.

Source files
------------

// File: rtl/pu_mac_stream.sv
// -----------------------------------------------------------------------------
// pu_mac_stream
//   Pipelined multi-lane dot-product unit. Every accepted beat multiplies LANES
//   input/weight pairs, reduces the products in a balanced adder tree and adds
//   the beat sum into a saturating accumulator. On the beat flagged in_last the
//   saturated packet result is presented on a valid/ready output port and the
//   accumulator restarts clean for the next packet.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   beat present on in_data / in_wgt / in_last
//   in_ready   unit can accept a beat this cycle
//   in_data    LANES packed operands, lane i = in_data[i*DATA_W +: DATA_W]
//   in_wgt     LANES packed weights, same packing
//   in_last    final beat of the current packet
//   out_valid  packet result available
//   out_ready  downstream accepts the result
//   out_data   accumulated, saturated dot product (ACC_W bits)
//   out_sat    saturation happened somewhere in this packet
//   out_beats  number of beats in this packet (saturating)
// -----------------------------------------------------------------------------
module pu_mac_stream #(
    parameter int LANES  = 4,
    parameter int DATA_W = 5,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*DATA_W-1:0]   in_wgt,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      out_sat,
    output logic [CNT_W-1:0]          out_beats
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    // Lane product. Operands are widened by one bit (sign or zero) so a single
    // signed multiply covers both modes; the low PROD_W bits always hold the
    // exact product for the selected interpretation.
    function automatic logic signed [PROD_W-1:0] mul_lane(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W:0]     ax;
        logic signed [DATA_W:0]     bx;
        logic signed [2*DATA_W+1:0] p;
        ax = (SIGNED != 0) ? {a[DATA_W-1], a} : {1'b0, a};
        bx = (SIGNED != 0) ? {b[DATA_W-1], b} : {1'b0, b};
        p  = ax * bx;
        return p[PROD_W-1:0];
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] x);
        logic signed [SUM_W-1:0] r;
        if (SIGNED != 0) r = {{(SUM_W-PROD_W){x[PROD_W-1]}}, x};
        else             r = {{(SUM_W-PROD_W){1'b0}}, x};
        return r;
    endfunction

    // Balanced reduction laid out as a binary heap: leaves at LANES..2*LANES-1,
    // node i sums its children 2i and 2i+1, the root is node 1.
    function automatic logic signed [SUM_W-1:0] tree_sum(
        input logic [LANES*PROD_W-1:0] p
    );
        logic signed [SUM_W-1:0] node [1:2*LANES-1];
        for (int i = 0; i < LANES; i++) begin
            node[LANES+i] = ext_prod(p[i*PROD_W +: PROD_W]);
        end
        for (int i = LANES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        return node[1];
    endfunction

    // Full-precision accumulate: one extra bit above ACC_W exposes overflow.
    function automatic logic signed [ACC_W:0] acc_add(
        input logic [ACC_W-1:0] a,
        input logic [SUM_W-1:0] s
    );
        logic signed [ACC_W:0] ax;
        logic signed [ACC_W:0] sx;
        if (SIGNED != 0) begin
            ax = {a[ACC_W-1], a};
            sx = {{(ACC_W+1-SUM_W){s[SUM_W-1]}}, s};
        end else begin
            ax = {1'b0, a};
            sx = {{(ACC_W+1-SUM_W){1'b0}}, s};
        end
        return ax + sx;
    endfunction

    function automatic logic acc_ovf(input logic [ACC_W:0] n);
        logic r;
        if (SIGNED != 0) r = n[ACC_W] ^ n[ACC_W-1];
        else             r = n[ACC_W];
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_sat(input logic [ACC_W:0] n);
        logic signed [ACC_W-1:0] r;
        r = n[ACC_W-1:0];
        if (SIGNED != 0) begin
            if (n[ACC_W] != n[ACC_W-1]) begin
                r = n[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (n[ACC_W]) begin
            r = '1;
        end
        return r;
    endfunction

    // Control state
    logic                     vld_p1_q, last_p1_q;
    logic                     vld_p2_q, last_p2_q;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sat_q, out_sat_d;
    logic                     sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         out_beats_q, out_beats_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;

    // Datapath registers (no reset; qualified by the stage valids)
    logic [LANES*PROD_W-1:0]  prod_p1_q;
    logic signed [SUM_W-1:0]  sum_p2_q;

    logic                     stall;
    logic                     accept;
    logic signed [ACC_W:0]    nxt;
    logic                     ovf;
    logic signed [ACC_W-1:0]  nxt_sat;
    logic [CNT_W-1:0]         cnt_inc;

    // A held result blocks the whole pipeline; nothing moves until it drains.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = rst & ~stall;
    assign accept   = in_valid & in_ready;

    // ---- S1: per-lane products ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
        end else if (!stall) begin
            vld_p1_q  <= accept;
            last_p1_q <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && accept) begin
            for (int i = 0; i < LANES; i++) begin
                prod_p1_q[i*PROD_W +: PROD_W] <=
                    mul_lane(in_data[i*DATA_W +: DATA_W], in_wgt[i*DATA_W +: DATA_W]);
            end
        end
    end

    // ---- S2: adder-tree beat sum ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
        end else if (!stall) begin
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && vld_p1_q) begin
            sum_p2_q <= tree_sum(prod_p1_q);
        end
    end

    // ---- S3: accumulate and present packet result ----
    assign nxt     = acc_add(acc_q, sum_p2_q);
    assign ovf     = acc_ovf(nxt);
    assign nxt_sat = acc_sat(nxt);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;
        if (!stall) begin
            // Not stalled means the current result (if any) is taken this edge.
            out_valid_d = 1'b0;
            if (vld_p2_q) begin
                if (last_p2_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = nxt_sat;
                    out_sat_d   = sat_flag_q | ovf;
                    out_beats_d = cnt_inc;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_flag_d  = 1'b0;
                end else begin
                    // Clamped value is kept; later beats build on it.
                    acc_d       = nxt_sat;
                    cnt_d       = cnt_inc;
                    sat_flag_d  = sat_flag_q | ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_flag_q  <= sat_flag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pu_mac_stream.sv
// -----------------------------------------------------------------------------
// tb_pu_mac_stream
//   Drives one shared beat stream into three configurations of the unit
//   (unsigned ACC_W=16, unsigned ACC_W=12, signed ACC_W=16) and compares every
//   presented result against a packet-level arithmetic model.
// -----------------------------------------------------------------------------
module tb_pu_mac_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [19:0] in_data;
    logic [19:0] in_wgt;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        os0, os1, os2;
    logic [15:0] od0;
    logic [11:0] od1;
    logic [15:0] od2;
    logic [7:0]  ob0, ob1, ob2;

    pu_mac_stream #(.LANES(4), .DATA_W(5), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u_u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_sat(os0), .out_beats(ob0));

    pu_mac_stream #(.LANES(4), .DATA_W(5), .ACC_W(12), .CNT_W(8), .SIGNED(0)) u_u12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_sat(os1), .out_beats(ob1));

    pu_mac_stream #(.LANES(4), .DATA_W(5), .ACC_W(16), .CNT_W(8), .SIGNED(1)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
        .in_data(in_data), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_sat(os2), .out_beats(ob2));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    typedef struct {
        longint d0, d1, d2;
        bit     s0, s1, s2;
        int     beats;
        int     due;
    } res_t;

    res_t   q[$];
    longint macc[3];
    bit     msat[3];
    int     mcnt;

    function automatic longint lo_lim(input int k);
        return (k == 2) ? -32768 : 0;
    endfunction

    function automatic longint hi_lim(input int k);
        return (k == 1) ? 4095 : ((k == 2) ? 32767 : 65535);
    endfunction

    function automatic longint beat_sum(input int k, input logic [19:0] d, input logic [19:0] w);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            longint a = longint'(d[i*5 +: 5]);
            longint b = longint'(w[i*5 +: 5]);
            if (k == 2 && a >= 16) a -= 32;
            if (k == 2 && b >= 16) b -= 32;
            s += a * b;
        end
        return s;
    endfunction

    function automatic longint pick_d(input res_t r, input int k);
        return (k == 0) ? r.d0 : ((k == 1) ? r.d1 : r.d2);
    endfunction

    function automatic longint pick_s(input res_t r, input int k);
        return (k == 0) ? longint'(r.s0) : ((k == 1) ? longint'(r.s1) : longint'(r.s2));
    endfunction

    function automatic longint act_d(input int k);
        return (k == 0) ? longint'(od0) : ((k == 1) ? longint'(od1) : longint'($signed(od2)));
    endfunction

    function automatic longint act_s(input int k);
        return (k == 0) ? longint'(os0) : ((k == 1) ? longint'(os1) : longint'(os2));
    endfunction

    function automatic longint act_b(input int k);
        return (k == 0) ? longint'(ob0) : ((k == 1) ? longint'(ob1) : longint'(ob2));
    endfunction

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < 3; k++) begin
            macc[k] = 0;
            msat[k] = 1'b0;
        end
        mcnt = 0;
    endtask

    task automatic model_beat(input logic [19:0] d, input logic [19:0] w, input logic last);
        res_t   r;
        longint t;
        bit     o;
        for (int k = 0; k < 3; k++) begin
            t = macc[k] + beat_sum(k, d, w);
            o = (t > hi_lim(k)) || (t < lo_lim(k));
            if (t > hi_lim(k)) t = hi_lim(k);
            if (t < lo_lim(k)) t = lo_lim(k);
            if (last) begin
                if (k == 0) begin r.d0 = t; r.s0 = msat[k] | o; end
                if (k == 1) begin r.d1 = t; r.s1 = msat[k] | o; end
                if (k == 2) begin r.d2 = t; r.s2 = msat[k] | o; end
                macc[k] = 0;
                msat[k] = 1'b0;
            end else begin
                macc[k] = t;
                msat[k] = msat[k] | o;
            end
        end
        if (last) begin
            r.beats = (mcnt + 1 > 255) ? 255 : mcnt + 1;
            r.due   = cyc + 3;
            q.push_back(r);
            mcnt = 0;
        end else begin
            mcnt = (mcnt + 1 > 255) ? 255 : mcnt + 1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("reset flags", longint'({ov0, ov1, ov2, os0, os1, os2, ir0, ir1, ir2}), 0);
            chk("reset data", longint'({od0, od1, od2}), 0);
            chk("reset beats", longint'({ob0, ob1, ob2}), 0);
            model_clear();
        end else begin
            chk("in_ready u16", longint'(ir0), longint'(!(ov0 && !out_ready)));
            chk("in_ready u12", longint'(ir1), longint'(!(ov1 && !out_ready)));
            chk("in_ready s16", longint'(ir2), longint'(!(ov2 && !out_ready)));
            if (ov0 || ov1 || ov2) begin
                if (q.size() == 0) begin
                    chk("unexpected out_valid", longint'(ov0 | ov1 | ov2), 0);
                end else begin
                    chk("out_valid agree", longint'({ov0, ov1, ov2}), 7);
                    chk("result too early", longint'(cyc >= q[0].due), 1);
                    for (int k = 0; k < 3; k++) begin
                        chk($sformatf("out_data[%0d]", k), act_d(k), pick_d(q[0], k));
                        chk($sformatf("out_sat[%0d]", k), act_s(k), pick_s(q[0], k));
                        chk($sformatf("out_beats[%0d]", k), act_b(k), longint'(q[0].beats));
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                chk("result overdue", longint'(cyc > q[0].due + 30), 0);
                if (cyc > q[0].due + 30) void'(q.pop_front());
            end
            if (in_valid && ir0) model_beat(in_data, in_wgt, in_last);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [19:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic send(input logic [19:0] d, input logic [19:0] w, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_wgt   = w;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (ir0) break;
            n++;
            if (n > 50) begin
                chk("in_ready wait", longint'(ir0), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges from the accepting edge of the last beat until out_valid is seen.
    task automatic wait_out(output int edges);
        edges = 1;
        forever begin
            @(negedge clk);
            if (ov0) break;
            @(posedge clk);
            edges++;
            if (edges > 40) begin
                chk("out_valid wait", longint'(ov0), 1);
                break;
            end
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] dA, wA, all31, m16, w15;
    int e;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_wgt    = '0;
        dA    = pack4(1, 2, 3, 4);
        wA    = pack4(5, 6, 7, 8);
        all31 = pack4(31, 31, 31, 31);
        m16   = pack4(16, 16, 16, 16);
        w15   = pack4(15, 15, 15, 15);
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready after release", longint'(ir0), 1);
        realign();

        // single-beat packet, latency
        send(dA, wA, 1'b1);
        wait_out(e);
        chk("t1 latency edges", e, 3);
        chk("t1 data", longint'(od0), 70);
        chk("t1 beats", longint'(ob0), 1);
        chk("t1 sat", longint'(os0), 0);
        realign();

        // three beats with bubbles
        send(dA, wA, 1'b0);
        idle(1);
        send(dA, wA, 1'b0);
        idle(1);
        send(dA, wA, 1'b1);
        wait_out(e);
        chk("t2 data", longint'(od0), 210);
        chk("t2 beats", longint'(ob0), 3);
        realign();

        // saturation on the 12-bit accumulator, then a clean packet
        send(all31, all31, 1'b0);
        send(all31, all31, 1'b1);
        wait_out(e);
        chk("t3 u12 data", longint'(od1), 4095);
        chk("t3 u12 sat", longint'(os1), 1);
        chk("t3 u16 data", longint'(od0), 7688);
        chk("t3 s16 data", longint'($signed(od2)), 8);
        realign();
        send(dA, wA, 1'b1);
        wait_out(e);
        chk("t3 next sat", longint'(os1), 0);
        chk("t3 next data", longint'(od1), 70);
        realign();

        // signed most-negative operand
        send(m16, w15, 1'b1);
        wait_out(e);
        chk("t4 s16 raw", longint'(od2), 64576);
        chk("t4 s16 value", longint'($signed(od2)), -960);
        chk("t4 u16 data", longint'(od0), 960);
        realign();

        // back-pressure with two packets queued
        out_ready = 1'b0;
        fork
            begin
                send(dA, wA, 1'b1);
                send(dA, wA, 1'b0);
                send(dA, wA, 1'b0);
                send(dA, wA, 1'b1);
            end
            begin
                int n = 0;
                forever begin
                    @(negedge clk);
                    if (ov0) break;
                    n++;
                    if (n > 40) begin
                        chk("t5 first result wait", longint'(ov0), 1);
                        break;
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    chk("t5 stall in_ready", longint'(ir0), 0);
                    chk("t5 stall data", longint'(od0), 70);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_out(e);
        chk("t5 second data", longint'(od0), 210);
        chk("t5 second beats", longint'(ob0), 3);
        realign();

        // reset mid-packet
        send(dA, wA, 1'b0);
        send(dA, wA, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6 out_data cleared", longint'(od0), 0);
        chk("t6 in_ready low", longint'(ir0), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(dA, wA, 1'b1);
        wait_out(e);
        chk("t6 data", longint'(od0), 70);
        chk("t6 beats", longint'(ob0), 1);
        realign();

        idle(6);
        chk("scoreboard drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
